mdu_ctrl: RTL and testbench

- Multiply/divide sequencer in the EX stage of the MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU as decoded 8-bit ALU control codes and runs signed or unsigned multiply (2-cycle) or radix-2 iterative divide (33+ cycles).
- Drives the pipeline stall while busy and presents the 64-bit {hi,lo} result for the HI/LO register write.
- Handles flush (exception/branch annul) and downstream hold.

---
 rtl/mdu_ctrl_pkg.sv | 38 +++
 rtl/mdu_ctrl_div_core.sv | 92 +++++++++
 rtl/mdu_ctrl.sv | 115 +++++++++++
 tb/tb_mdu_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// ============================================================================
// mdu_ctrl_pkg : shared ALU op codes, FSM states and op decode helpers
// Revision     : 1.0
// ============================================================================
`default_nettype none

package mdu_ctrl_pkg;

    localparam int MDU_WIDTH = 32;

    localparam logic [7:0] ADD_OP   = 8'h20;
    localparam logic [7:0] MULT_OP  = 8'h18;
    localparam logic [7:0] MULTU_OP = 8'h19;
    localparam logic [7:0] DIV_OP   = 8'h1A;
    localparam logic [7:0] DIVU_OP  = 8'h1B;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MUL     = 2'd1,
        S_DIV_RUN = 2'd2,
        S_DONE    = 2'd3
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [7:0] op);
        return (op == MULT_OP) || (op == MULTU_OP) || (op == DIV_OP) || (op == DIVU_OP);
    endfunction

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == DIV_OP) || (op == DIVU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == MULT_OP) || (op == DIV_OP);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_ctrl_div_core.sv
// ============================================================================
// div_core : radix-2 restoring divider with magnitude setup and sign fix-up
// Revision : 1.0
// ============================================================================
`default_nettype none

module div_core #(
    parameter int WIDTH      = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int            CW   = $clog2(DIV_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);

    logic             run_q;
    logic             dz_q;
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dvs_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_sub;
    logic             fits;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign mag_a = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign mag_b = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
    assign rem_sub = rem_sh - {1'b0, dvs_q};
    assign fits    = ~rem_sub[WIDTH];
    assign rem_d   = fits ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_d   = {quo_q[WIDTH-2:0], fits};

    assign done_o = run_q && (dz_q || (cnt_q == LAST));
    assign quo_o  = dz_q ? '1    : (neg_quo_q ? (~quo_d + 1'b1) : quo_d);
    assign rem_o  = dz_q ? rem_q : (neg_rem_q ? (~rem_d + 1'b1) : rem_d);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            run_q     <= 1'b0;
            dz_q      <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            dvs_q     <= '0;
        end else if (abort_i) begin
            run_q <= 1'b0;
        end else if (start_i) begin
            run_q     <= 1'b1;
            cnt_q     <= '0;
            dz_q      <= (b_i == '0);
            dvs_q     <= mag_b;
            quo_q     <= mag_a;
            // A zero divisor returns the raw dividend as the remainder.
            rem_q     <= (b_i == '0) ? a_i : '0;
            neg_quo_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_q <= signed_i && a_i[WIDTH-1];
        end else if (run_q) begin
            if (done_o) begin
                run_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
                rem_q <= rem_d;
                quo_q <= quo_d;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mdu_ctrl.sv
// ============================================================================
// mdu_ctrl : EX-stage multiply/divide sequencer producing the {hi,lo} result
// Revision : 1.0
// ============================================================================
`default_nettype none

module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int WIDTH      = MDU_WIDTH,
    parameter int DIV_CYCLES = WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic [7:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             flush_i,
    input  logic             hold_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    mdu_state_e       state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sgn_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             accept;
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] prod;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign accept = (state_q == S_IDLE) && start_i && !flush_i && is_mdu_op(op_i);

    // Low 2W bits of the product of extended operands are correct for both signednesses.
    assign ext_a = sgn_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign ext_b = sgn_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign prod  = ext_a * ext_b;

    div_core #(
        .WIDTH      (WIDTH),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_div_core (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (accept && is_div_op(op_i)),
        .abort_i  (flush_i),
        .signed_i (is_signed_op(op_i)),
        .a_i      (a_i),
        .b_i      (b_i),
        .done_o   (div_done),
        .quo_o    (div_quo),
        .rem_o    (div_rem)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush_i) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        sgn_q   <= is_signed_op(op_i);
                        state_q <= is_div_op(op_i) ? S_DIV_RUN : S_MUL;
                    end
                end
                S_MUL: begin
                    {hi_q, lo_q} <= prod;
                    state_q      <= S_DONE;
                end
                S_DIV_RUN: begin
                    if (div_done) begin
                        hi_q    <= div_rem;
                        lo_q    <= div_quo;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (!hold_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall_o = accept || (state_q == S_MUL) || (state_q == S_DIV_RUN);
    assign busy_o  = (state_q != S_IDLE);
    assign done_o  = (state_q == S_DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
// ============================================================================
// tb_mdu_ctrl : directed self-checking bench for the multiply/divide sequencer
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        start_i;
    logic [7:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        hold_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu_ctrl dut (
        .clk     (clk),
        .resetn  (resetn),
        .start_i (start_i),
        .op_i    (op_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .flush_i (flush_i),
        .hold_i  (hold_i),
        .stall_o (stall_o),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .hi_o    (hi_o),
        .lo_o    (lo_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op from a negedge; returns stall count and the cycle done_o first rises.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int stall_cnt, output int done_cyc);
        start_i   = 1'b1;
        op_i      = op;
        a_i       = a;
        b_i       = b;
        stall_cnt = 0;
        done_cyc  = -1;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (done_o) begin
                done_cyc = c;
                break;
            end
            if (stall_o) stall_cnt++;
            tick();
            start_i = 1'b0;
        end
        start_i = 1'b0;
    endtask

    int          st;
    int          dc;
    int          n;
    logic        seen;
    logic [31:0] hi_keep;
    logic [31:0] lo_keep;

    initial begin
        resetn  = 1'b0;
        start_i = 1'b0;
        op_i    = 8'h00;
        a_i     = '0;
        b_i     = '0;
        flush_i = 1'b0;
        hold_i  = 1'b0;
        tick();
        tick();
        chk("reset_ctl", {61'd0, stall_o, busy_o, done_o}, 64'd0);
        chk("reset_hilo", {hi_o, lo_o}, 64'd0);
        resetn = 1'b1;
        tick();

        // Non-MDU op: ignored
        start_i = 1'b1; op_i = ADD_OP; a_i = 32'd3; b_i = 32'd4;
        #1 chk("add_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0;
        #1 chk("add_busy", 64'(busy_o), 64'd0);
        tick();

        // DIVU 100/7
        run_op(DIVU_OP, 32'd100, 32'd7, st, dc);
        chk("divu_stall", 64'(st), 64'd33);
        chk("divu_done_cyc", 64'(dc), 64'd33);
        chk("divu_hilo", {hi_o, lo_o}, {32'h0000_0002, 32'h0000_000E});
        tick();
        #1 chk("divu_done_drop", 64'(done_o), 64'd0);
        chk("divu_retain", {hi_o, lo_o}, {32'h0000_0002, 32'h0000_000E});
        tick();

        run_op(DIV_OP, 32'hFFFF_FFF9, 32'd2, st, dc);
        chk("div_neg_cyc", 64'(dc), 64'd33);
        chk("div_neg_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        tick();

        run_op(DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, st, dc);
        chk("div_ovf_hilo", {hi_o, lo_o}, {32'h0000_0000, 32'h8000_0000});
        tick();

        run_op(MULT_OP, 32'hFFFF_FFFF, 32'd2, st, dc);
        chk("mult_stall", 64'(st), 64'd2);
        chk("mult_done_cyc", 64'(dc), 64'd2);
        chk("mult_hilo", {hi_o, lo_o}, {32'hFFFF_FFFF, 32'hFFFF_FFFE});
        tick();

        run_op(MULTU_OP, 32'hFFFF_FFFF, 32'd2, st, dc);
        chk("multu_hilo", {hi_o, lo_o}, {32'h0000_0001, 32'hFFFF_FFFE});
        tick();

        run_op(DIVU_OP, 32'h0000_1234, 32'd0, st, dc);
        chk("dz_stall", 64'(st), 64'd2);
        chk("dz_done_cyc", 64'(dc), 64'd2);
        chk("dz_hilo", {hi_o, lo_o}, {32'h0000_1234, 32'hFFFF_FFFF});
        tick();

        // Flush in the accept cycle suppresses it
        start_i = 1'b1; op_i = DIVU_OP; a_i = 32'd50; b_i = 32'd5; flush_i = 1'b1;
        #1 chk("flush_acc_stall", 64'(stall_o), 64'd0);
        tick();
        start_i = 1'b0; flush_i = 1'b0;
        #1 chk("flush_acc_busy", 64'(busy_o), 64'd0);
        tick();

        // Flush at cycle 10 of a divide
        hi_keep = hi_o; lo_keep = lo_o;
        start_i = 1'b1; op_i = DIV_OP; a_i = 32'd1000; b_i = 32'd3;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        flush_i = 1'b1;
        #1 chk("flush10_busy_before", 64'(busy_o), 64'd1);
        tick();
        flush_i = 1'b0;
        #1 chk("flush10_idle", {62'd0, busy_o, stall_o}, 64'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1 seen |= done_o;
            tick();
        end
        chk("flush10_no_done", 64'(seen), 64'd0);
        chk("flush10_hilo", {hi_o, lo_o}, {hi_keep, lo_keep});

        // Reset at cycle 10 of a divide
        start_i = 1'b1; op_i = DIV_OP; a_i = 32'd1000; b_i = 32'd3;
        tick();
        start_i = 1'b0;
        repeat (9) tick();
        resetn = 1'b0;
        #1 chk("rst10_ctl", {61'd0, stall_o, busy_o, done_o}, 64'd0);
        chk("rst10_hilo", {hi_o, lo_o}, 64'd0);
        tick();
        resetn = 1'b1;
        tick();
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            #1 seen |= done_o | busy_o;
            tick();
        end
        chk("rst10_stays_idle", 64'(seen), 64'd0);
        chk("rst10_hilo_after", {hi_o, lo_o}, 64'd0);

        // MULTU with hold for 3 DONE cycles, start_i ignored during DONE
        hold_i = 1'b1;
        run_op(MULTU_OP, 32'h0001_0000, 32'h0001_0000, st, dc);
        chk("hold_done_cyc", 64'(dc), 64'd2);
        start_i = 1'b1; op_i = DIVU_OP; a_i = 32'd9; b_i = 32'd1;
        n = 0;
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin
                hold_i  = 1'b0;
                start_i = 1'b0;
            end
            #1 if (done_o) n++;
            tick();
        end
        chk("hold_done_count", 64'(n), 64'd4);
        chk("hold_no_restart", {62'd0, busy_o, stall_o}, 64'd0);
        chk("hold_hilo", {hi_o, lo_o}, {32'h0000_0001, 32'h0000_0000});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
